// File: rtl/prog_sequencer.sv
// Run controller for the 9-bit core: start edge -> core reset -> PC load -> run until halt.
// Define SEQ_WATCHDOG_EN to end runs that never halt after TIMEOUT RUN cycles.
module prog_sequencer #(
  parameter int               PC_W     = 8,
  parameter int               CYC_W    = 16,
  parameter int               RST_CYC  = 2,
  parameter logic [PC_W-1:0]  PROG0_PC = 8'd0,
  parameter logic [PC_W-1:0]  PROG1_PC = 8'd64,
  parameter logic [PC_W-1:0]  PROG2_PC = 8'd128,
  parameter logic [CYC_W-1:0] TIMEOUT  = 16'd4000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       prog_sel,
  input  logic             core_halt,
  output logic             core_rst,
  output logic             core_run,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_init,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CYC_W-1:0] cycles
);

  localparam int RC_W = (RST_CYC < 2) ? 1 : $clog2(RST_CYC + 1);

`ifdef SEQ_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RESET, LOAD, RUN, DONE} state_t;

  state_t          state;
  logic            start_q;
  logic [RC_W-1:0] rst_cnt;
  logic            launch;
  logic [PC_W-1:0] sel_pc;
  logic [CYC_W-1:0] cyc_next;
  logic            limit_hit;

  assign launch = start & ~start_q;

  // Code 3 is reserved and quietly falls back to program 0.
  always_comb begin
    case (prog_sel)
      2'd1:    sel_pc = PROG1_PC;
      2'd2:    sel_pc = PROG2_PC;
      default: sel_pc = PROG0_PC;
    endcase
  end

  // The limit is compared against the count including the current RUN cycle.
  assign cyc_next  = (&cycles) ? cycles : cycles + CYC_W'(1);
  assign limit_hit = WD_EN && (cyc_next == TIMEOUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      rst_cnt  <= '0;
      core_rst <= 1'b1;
      core_run <= 1'b0;
      pc_load  <= 1'b0;
      pc_init  <= PROG0_PC;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      cycles   <= '0;
    end else begin
      start_q <= start;
      if (launch && (state == IDLE || state == DONE)) begin
        state    <= RESET;
        rst_cnt  <= RC_W'(RST_CYC);
        pc_init  <= sel_pc;
        core_rst <= 1'b1;
        core_run <= 1'b0;
        pc_load  <= 1'b0;
        busy     <= 1'b1;
        done     <= 1'b0;
        timeout  <= 1'b0;
        cycles   <= '0;
      end else begin
        case (state)
          RESET: begin
            if (rst_cnt == RC_W'(1)) begin
              state    <= LOAD;
              core_rst <= 1'b0;
              pc_load  <= 1'b1;
            end else begin
              rst_cnt <= rst_cnt - RC_W'(1);
            end
          end
          LOAD: begin
            state    <= RUN;
            pc_load  <= 1'b0;
            core_run <= 1'b1;
          end
          RUN: begin
            cycles <= cyc_next;
            // Halt takes priority over the watchdog when both land on the same cycle.
            if (core_halt || limit_hit) begin
              state    <= DONE;
              core_run <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              timeout  <= ~core_halt;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Run controller between the top-level `start`/`done` pins and the 9-bit-instruction processor core. It detects a start request, holds the core in reset, and loads the start PC of the selected program. It then enables execution until the core halts, and reports `done` together with an executed-cycle count. An optional watchdog forces `done` if the program never halts.

## Interface
Parameters:
- `PC_W`, 8, width of core PC
- `CYC_W`, 16, width of cycle counter
- `RST_CYC`, 2, cycles `core_rst` is held high per launch (≥1)
- `PROG0_PC`, 8'd0, start PC of program 0
- `PROG1_PC`, 8'd64, start PC of program 1
- `PROG2_PC`, 8'd128, start PC of program 2
- `TIMEOUT`, 16'd4000, watchdog limit in RUN cycles (used only with `SEQ_WATCHDOG_EN`)

Ports:
- `clk`  in  1  single system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  run request, level; a 0→1 transition launches a run
- `prog_sel`  in  2  program select, sampled on the launching edge
- `core_halt`  in  1  core reached its halt instruction
- `core_rst`  out  1  synchronous reset to core
- `core_run`  out  1  core clock-enable / advance
- `pc_load`  out  1  one-cycle strobe: core PC ← `pc_init`
- `pc_init`  out  PC_W  start PC of the latched program
- `busy`  out  1  run in progress (states RESET, LOAD, RUN)
- `done`  out  1  run finished; held until next launch
- `timeout`  out  1  run ended by watchdog
- `cycles`  out  CYC_W  RUN cycles of the last/current run

## Operation
- States: IDLE, RESET, LOAD, RUN, DONE.
- Edge detect: `start_q` register; launch = `start & ~start_q`.
- `start_q` resets to 0, so `start` high on the first cycle after `rst` falls counts as a launch.
- IDLE:
  - Outputs: `core_rst`=1, `core_run`=0.
  - On launch, latch `prog_sel`, clear `cycles`/`timeout`/`done`, load a reset counter with `RST_CYC`, and go to RESET.
- Program map:
  - 0 → `PROG0_PC`, 1 → `PROG1_PC`, 2 → `PROG2_PC`.
  - 3 → `PROG0_PC`; code 3 is reserved and raises no error.
- RESET:
  - `core_rst`=1; decrement the reset counter each cycle.
  - After exactly `RST_CYC` cycles, go to LOAD.
- LOAD:
  - Exactly one cycle: `core_rst`=0, `pc_load`=1, `core_run`=0.
  - Then go to RUN.
- RUN:
  - `core_run`=1; `cycles` increments every RUN cycle and saturates at all-ones.
  - `core_halt`=1 → go to DONE. The halt cycle is counted.
- DONE:
  - `done`=1, `core_run`=0, `core_rst`=0, so core state stays inspectable. `cycles` is frozen.
  - A new launch clears `done` and goes to RESET.
  - `start` held high does not relaunch.
- Launches in RESET, LOAD and RUN are ignored, but `start_q` still tracks `start`.
- `pc_init` is driven continuously from the latched selection. It is valid from RESET onward.

## Timing
- Reset values (every output and register, effective the cycle after `rst` is sampled high, in any state):
  - state=IDLE, `core_rst`=1, `core_run`=0, `pc_load`=0.
  - `busy`=0, `done`=0, `timeout`=0, `cycles`=0.
  - `pc_init`=`PROG0_PC`, `start_q`=0.
- Reset mid-run aborts immediately; the core stays in reset.
- All outputs are registered or decoded from state only; no combinational input→output paths.
- Launch sampled at edge N:
  - RESET occupies cycles N+1 … N+RST_CYC.
  - LOAD occupies cycle N+RST_CYC+1.
  - First RUN cycle is N+RST_CYC+2.
- `core_halt` sampled high in RUN at edge M → `done`=1 from cycle M+1; `cycles` = number of RUN cycles including M.
- Launch latency from `start` rise to first `core_run` = RST_CYC+2 cycles (4 at default).
- `core_halt` outside RUN is ignored.

## Configuration
- `SEQ_WATCHDOG_EN` defined:
  - In RUN, if `cycles` == `TIMEOUT` on a cycle with `core_halt`=0, go to DONE with `timeout`=1.
  - If `core_halt` and the limit coincide, halt wins and `timeout`=0.
  - `timeout` clears on the next launch or reset.
- Not defined:
  - `timeout` is tied 0 and RUN waits indefinitely for `core_halt`.
  - `cycles` saturates.

## Test plan
- Reset, then `start`=1 on the same edge `rst` falls, `prog_sel`=0, halt after 10 RUN cycles → `core_rst` high 2 cycles, `pc_load` pulses with `pc_init`=0, `core_run` first high 4 cycles after launch, `done`=1, `cycles`=10.
- Hold `start` high through DONE for 50 cycles → no relaunch, `done` stays 1.
- Drop `start`, raise it again with `prog_sel`=2 → `done` clears, `pc_init`=128, new `cycles` counts from 1.
- Assert `rst` for 1 cycle in the middle of RUN → next cycle IDLE, `core_rst`=1, `busy`=0, `cycles`=0. A launch toggled during RUN before the reset was ignored.
- `SEQ_WATCHDOG_EN`, `TIMEOUT`=20, `core_halt` never asserted → DONE after 20 RUN cycles with `timeout`=1, `cycles`=20. Repeat with `core_halt` on cycle 20 → `timeout`=0.
- `prog_sel`=3 → `pc_init`=`PROG0_PC`. Pulse `core_halt` in IDLE and LOAD → no state change.
